axis_pipe_rx_buffer: RTL and testbench
======================================

# axis_pipe_rx_buffer

Receive-side elastic buffer for AXI4S links whose forward path is a valid-only register pipeline and whose ready is returned upstream through a delayed path. It absorbs every beat still in flight after it withdraws ready. It drives the early ready that the sender's pipeline carries back, and presents a normal valid/ready AXI4S master to the local consumer. It sits at the far end of long, multi-stage stream links that cross the die.

## Interface
- DATA_BITS, 32: tdata width.
- DEPTH, 32: buffer entries; power of two, at least 4.
- RTT_BEATS, 8: maximum number of beats that can arrive after s_ready_early falls, counting both forward and return pipeline stages. Must be less than DEPTH.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  incoming beat. There is no backpressure on this path, so every asserted cycle is one beat.
- s_axis_tdata  in  DATA_BITS  incoming data.
- s_ready_early  out  1  registered permission-to-send, returned upstream through the delay pipeline.
- m_axis_tvalid  out  1  head entry valid.
- m_axis_tdata  out  DATA_BITS  head entry data.
- m_axis_tready  in  1  consumer ready.
- fill_count  out  $clog2(DEPTH)+1  occupied entries, registered.
- overflow  out  1  sticky flag: a beat was dropped.

## Operation
- Storage is a circular buffer addressed by wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. The occupancy counter `count` ranges 0..DEPTH.
- Push is s_axis_tvalid AND (count < DEPTH OR pop).
- Pop is m_axis_tvalid AND m_axis_tready.
- Count update, per cycle:
  - count_next = count + push − pop.
  - push alone: +1.
  - pop alone: −1.
  - both: unchanged.
- Full with simultaneous pop: the incoming beat is accepted into the slot freed by the pop.
- Drop rule: s_axis_tvalid with count == DEPTH and no pop.
  - The beat is discarded and wr_ptr does not move.
  - overflow is set and holds 1 until areset.
- Output path:
  - m_axis_tvalid = (count != 0).
  - m_axis_tdata = entry at rd_ptr.
  - m_axis_tdata is stable while m_axis_tvalid is high and m_axis_tready is low.
- Ready generation: s_ready_early_next = (DEPTH − count_next) > RTT_BEATS.
  - Registered, so the value reflects occupancy after the current cycle's push/pop.
  - Guarantees no overflow when the upstream honours s_ready_early with a round trip of at most RTT_BEATS.
- fill_count = count.
- The block does not inspect data; beat order is strictly preserved.
- Reset mid-operation: all buffered beats are discarded, both pointers go to 0, and overflow is cleared. A beat presented in the reset cycle is not stored.

## Timing
- Reset values:
  - s_ready_early = 0.
  - m_axis_tvalid = 0.
  - fill_count = 0.
  - overflow = 0.
  - m_axis_tdata is don't-care.
- s_ready_early rises on the first edge after areset deasserts.
- Latency: a beat pushed into an empty buffer at edge t gives m_axis_tvalid = 1 with that data after edge t; the consumer can pop it at edge t+1.
- Throughput: one push and one pop per cycle, sustained.
- s_ready_early falls on the edge where count_next exceeds DEPTH − RTT_BEATS − 1. It rises on the edge where count_next drops back to DEPTH − RTT_BEATS − 1 or below. There is no hysteresis.
- overflow is set on the same edge as the dropped beat.
- Pointer wrap: both pointers wrap from DEPTH−1 to 0 with no bubble.

## Test plan
- Reset then idle: after areset is released, check s_ready_early = 1 one edge later, m_axis_tvalid = 0, fill_count = 0, overflow = 0.
- Streaming: with m_axis_tready held at 1, push 100 incrementing beats (0..99) back to back. Required response:
  - output equals 0..99 in order;
  - fill_count never exceeds 1;
  - s_ready_early stays 1.
- Threshold (DEPTH=32, RTT_BEATS=8), with m_axis_tready = 0:
  - push 23 beats: s_ready_early is still 1;
  - 24th beat: s_ready_early falls on that edge;
  - a further 8 beats fill to 32 with overflow = 0;
  - then 2 pops bring count to 30 and s_ready_early stays 0;
  - pops continue until count = 23, where s_ready_early rises.
- Full with simultaneous push and pop at count = 32: the push is accepted, count stays 32, overflow = 0, and the data order is intact.
- Overflow: at count = 32 with no pop, push value 0xDEAD. Required response: overflow = 1 and sticky; 0xDEAD never appears on the output.
- Mid-stream reset: with count = 10, assert areset for 1 cycle while s_axis_tvalid = 1. Required response:
  - m_axis_tvalid = 0 and fill_count = 0 after that edge;
  - the next pushed beat is the next one output.

Source files
------------

// File: rtl/axis_pipe_rx_buffer_if.sv
// axis_pipe_rx_buffer_if
//   Stream bundle used on both sides of the receive buffer.
//   Handshake: a beat moves on every rising edge where tvalid and tready are both 1.
//   On the forward link into the buffer, tvalid is not qualified by tready.
//   Every asserted tvalid there is a beat.
//   On that link, tready carries the registered early ready back upstream through the return pipeline.
//   Signals:
//     tvalid  master -> slave  beat present
//     tdata   master -> slave  payload, DATA_BITS wide
//     tready  slave  -> master consumer ready / early permission-to-send
interface axis_pipe_rx_buffer_if #(
    parameter int DATA_BITS = 32
);
    logic                 tvalid;
    logic [DATA_BITS-1:0] tdata;
    logic                 tready;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/axis_pipe_rx_buffer.sv
// axis_pipe_rx_buffer
//   Elastic receive buffer at the far end of a valid-only pipelined stream link.
//   The buffer absorbs the beats still in flight after early ready drops.
//   It presents a normal valid/ready stream to the local consumer.
//   Ports:
//     aclk        clock, rising edge
//     areset      synchronous active-high reset
//     s_axis      incoming link (slave). tvalid/tdata are inputs.
//                 tready is driven with s_ready_early.
//     m_axis      outgoing stream (master) to the local consumer
//     fill_count  occupied entries (0..DEPTH), registered
//     overflow    sticky: a beat arrived while full with no pop and was dropped
//   Parameters: DEPTH is a power of two, >= 4; RTT_BEATS < DEPTH.
module axis_pipe_rx_buffer #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 32,
    parameter int RTT_BEATS = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    axis_pipe_rx_buffer_if.slave      s_axis,
    axis_pipe_rx_buffer_if.master     m_axis,
    output logic [$clog2(DEPTH):0]    fill_count,
    output logic                      overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    // Largest occupancy that still leaves more than RTT_BEATS free slots.
    localparam logic [CW-1:0] READY_MAX  = CW'(DEPTH - RTT_BEATS - 1);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ready_q, ready_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, drop;

    always_comb begin
        pop  = (count_q != '0) && m_axis.tready;
        // When full, a beat is still accepted if a pop frees a slot on the same edge.
        push = s_axis.tvalid && ((count_q != FULL_COUNT) || pop);
        drop = s_axis.tvalid && !push;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        // Ready is computed from the post-edge occupancy, so it reacts on the same edge.
        ready_d    = (count_d <= READY_MAX);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; the write is gated so a beat seen during reset is never stored.
    always_ff @(posedge aclk) begin
        if (!areset && push) begin
            mem_q[wr_ptr_q] <= s_axis.tdata;
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = (count_q != '0);
    assign m_axis.tdata  = mem_q[rd_ptr_q];
    assign fill_count    = count_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_axis_pipe_rx_buffer.sv
module tb_axis_pipe_rx_buffer;
  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int RTT   = 8;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axis_pipe_rx_buffer_if #(.DATA_BITS(W)) s_if ();
  axis_pipe_rx_buffer_if #(.DATA_BITS(W)) m_if ();
  logic [$clog2(DEPTH):0] fill_count;
  logic                   overflow;

  axis_pipe_rx_buffer #(.DATA_BITS(W), .DEPTH(DEPTH), .RTT_BEATS(RTT)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .fill_count (fill_count),
    .overflow   (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_ready = 1'b0;
  logic         exp_ovf = 1'b0;
  int           n_vec = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer seen as an ordered list of beats: consumer takes the head, sender appends,
  // a full list with nothing leaving loses the new beat.
  task automatic model_edge(input logic rst, input logic v, input logic [W-1:0] d, input logic tr);
    bit take;
    if (rst) begin
      exp_q.delete();
      exp_ready = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      take = (exp_q.size() > 0) && tr;
      if (take) void'(exp_q.pop_front());
      if (v) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf = 1'b1;
      end
      exp_ready = ((DEPTH - exp_q.size()) > RTT);
    end
  endtask

  task automatic check_model();
    chk("m_tvalid", m_if.tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_tdata", m_if.tdata, exp_q[0]);
    chk("fill_count", fill_count, exp_q.size());
    chk("s_ready_early", s_if.tready, exp_ready);
    chk("overflow", overflow, exp_ovf);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic [W-1:0] d, input logic tr);
    areset      = rst;
    s_if.tvalid = v;
    s_if.tdata  = d;
    m_if.tready = tr;
    @(posedge aclk);
    model_edge(rst, v, d, tr);
    #1;
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         tr;
    logic         e_valid;
    logic [W-1:0] e_data;
    int           e_fill;
    logic         e_ready;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] seq;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 32'h0,  0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'hA5, 1'b0, 1'b1, 32'hA5, 1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h5A, 1'b1, 1'b1, 32'h5A, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 2, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0};

    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].tr);
      chk("tbl_valid", m_if.tvalid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk("tbl_data", m_if.tdata, vecs[i].e_data);
      chk("tbl_fill", fill_count, vecs[i].e_fill);
      chk("tbl_ready", s_if.tready, vecs[i].e_ready);
      chk("tbl_ovf", overflow, vecs[i].e_ovf);
    end

    // Streaming 0..99 with consumer always ready.
    seq = '0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, W'(i), 1'b1);
      chk("stream_data", m_if.tdata, seq);
      seq = seq + 1;
      chk("stream_fill_le1", fill_count <= 1, 1'b1);
      chk("stream_ready", s_if.tready, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    chk("stream_empty", m_if.tvalid, 1'b0);

    // Threshold walk with consumer stalled.
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1, W'(32'h1000 + i), 1'b0);
    chk("thr_23_ready", s_if.tready, 1'b1);
    step(1'b0, 1'b1, 32'h1017, 1'b0);
    chk("thr_24_ready", s_if.tready, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, W'(32'h1018 + i), 1'b0);
    chk("thr_32_fill", fill_count, 32);
    chk("thr_32_ovf", overflow, 1'b0);

    // Full with simultaneous push and pop.
    step(1'b0, 1'b1, 32'h2000, 1'b1);
    chk("fullpp_fill", fill_count, 32);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_head", m_if.tdata, 32'h1001);

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("thr_30_fill", fill_count, 30);
    chk("thr_30_ready", s_if.tready, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("thr_24_fill", fill_count, 24);
    chk("thr_24_still_low", s_if.tready, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("thr_23_fill", fill_count, 23);
    chk("thr_23_rise", s_if.tready, 1'b1);

    // Overflow: fill up, push 0xDEAD with no pop.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, W'(32'h3000 + i), 1'b0);
    chk("ovf_pre_fill", fill_count, 32);
    step(1'b0, 1'b1, 32'hDEAD, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_fill", fill_count, 32);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (m_if.tvalid) chk("ovf_no_dead", m_if.tdata == 32'hDEAD, 1'b0);
    end
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_drained", fill_count, 0);

    // Mid-stream reset with a beat presented during reset.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(32'h4000 + i), 1'b0);
    chk("rst_pre_fill", fill_count, 10);
    step(1'b1, 1'b1, 32'hBEEF, 1'b0);
    chk("rst_valid", m_if.tvalid, 1'b0);
    chk("rst_fill", fill_count, 0);
    chk("rst_ovf", overflow, 1'b0);
    step(1'b0, 1'b1, 32'h1234, 1'b0);
    chk("rst_next_valid", m_if.tvalid, 1'b1);
    chk("rst_next_data", m_if.tdata, 32'h1234);
    step(1'b0, 1'b0, '0, 1'b1);

    // Random traffic ignoring ready: exercises drops, wrap and full push/pop.
    for (int i = 0; i < 1500; i++)
      step(1'b0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1);

    // Random traffic with the sender honouring early ready: must never overflow.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 1500; i++)
      step(1'b0, s_if.tready && ($urandom_range(0, 3) != 0), $urandom,
           $urandom_range(0, 2) == 0);
    chk("honour_no_ovf", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
